// File: rtl/mult_unit_pkg.sv
// Shared types and constants for the MULT/MULTU/MTHI/MTLO unit.
package mult_unit_pkg;

  localparam int unsigned WIDTH     = 32;
  localparam int unsigned CNT_WIDTH = 5;
  localparam int unsigned MULT_ITER = 32;

  localparam logic [CNT_WIDTH-1:0] LAST_ITER = CNT_WIDTH'(MULT_ITER - 1);

  localparam logic [5:0] FUNCT_MULT  = 6'h18;
  localparam logic [5:0] FUNCT_MULTU = 6'h19;
  localparam logic [5:0] FUNCT_MTHI  = 6'h11;
  localparam logic [5:0] FUNCT_MTLO  = 6'h13;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FIXLO = 2'd2,
    FIXHI = 2'd3
  } state_t;

  // Magnitude of a signed operand; 0x8000_0000 maps onto itself, which is its correct unsigned magnitude.
  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] x, input logic isSigned);
    return (isSigned && x[WIDTH-1]) ? (~x + WIDTH'(1)) : x;
  endfunction

endpackage

// File: rtl/mult_unit_if.sv
// Execute-stage bus between the pipeline and the multiply unit.
interface mult_unit_if;
  import mult_unit_pkg::*;

  logic             start;
  logic             isSigned;
  logic [WIDTH-1:0] opA;
  logic [WIDTH-1:0] opB;
  logic             hiWrite;
  logic             loWrite;
  logic [WIDTH-1:0] writeData;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, isSigned, opA, opB, hiWrite, loWrite, writeData,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, isSigned, opA, opB, hiWrite, loWrite, writeData,
    output busy, done, hi, lo
  );
endinterface

// File: rtl/mult_unit_adder.sv
// 32-bit ripple-style full adder shared with the ALU datapath.
module thirtytwoBitFullAdder
  import mult_unit_pkg::*;
(
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carryIn,
  output logic [WIDTH-1:0] sum,
  output logic             carryOut
);

  assign {carryOut, sum} = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, carryIn};

endmodule

// File: rtl/mult_unit.sv
// Iterative shift-add multiplier with architectural HI/LO; magnitudes multiplied, sign fixed up in two adder passes.
module mult_unit
  import mult_unit_pkg::*;
(
  input  logic        clk,
  input  logic        rstN,
  mult_unit_if.slave  bus
);

  state_t                 state;
  state_t                 nextState;
  logic                   busyD;
  logic                   doneD;
  logic [CNT_WIDTH-1:0]   cnt;
  logic [WIDTH-1:0]       acc;
  logic [WIDTH-1:0]       mplier;
  logic [WIDTH-1:0]       mcand;
  logic [WIDTH-1:0]       loWord;
  logic                   neg;
  logic                   fixCarry;
  logic [WIDTH-1:0]       addA;
  logic [WIDTH-1:0]       addB;
  logic                   addCin;
  logic [WIDTH-1:0]       sum;
  logic                   carryOut;

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) state <= IDLE;
    else       state <= nextState;
  end

  always_comb begin
    nextState = state;
    doneD     = 1'b0;
    unique case (state)
      IDLE:  if (bus.start) nextState = RUN;
      RUN:   if (cnt == LAST_ITER) nextState = FIXLO;
      FIXLO: nextState = FIXHI;
      FIXHI: begin
        nextState = IDLE;
        doneD     = 1'b1;
      end
      default: nextState = IDLE;
    endcase
    busyD = (nextState != IDLE);
  end

  // Single adder: accumulate in RUN, conditional two's-complement of the 64-bit result in FIXLO/FIXHI.
  always_comb begin
    addA   = '0;
    addB   = '0;
    addCin = 1'b0;
    unique case (state)
      RUN: begin
        addA = acc;
        addB = mplier[0] ? mcand : '0;
      end
      FIXLO: begin
        addA   = neg ? ~mplier : mplier;
        addCin = neg;
      end
      FIXHI: begin
        addA   = neg ? ~acc : acc;
        addCin = fixCarry;
      end
      default: ;
    endcase
  end

  thirtytwoBitFullAdder uAdder (
    .a        (addA),
    .b        (addB),
    .carryIn  (addCin),
    .sum      (sum),
    .carryOut (carryOut)
  );

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      cnt      <= '0;
      acc      <= '0;
      mplier   <= '0;
      mcand    <= '0;
      loWord   <= '0;
      neg      <= 1'b0;
      fixCarry <= 1'b0;
    end else begin
      unique case (state)
        IDLE: if (bus.start) begin
          neg    <= bus.isSigned & (bus.opA[WIDTH-1] ^ bus.opB[WIDTH-1]);
          mcand  <= magnitude(bus.opA, bus.isSigned);
          mplier <= magnitude(bus.opB, bus.isSigned);
          acc    <= '0;
          cnt    <= '0;
        end
        RUN: begin
          acc    <= {carryOut, sum[WIDTH-1:1]};
          mplier <= {sum[0], mplier[WIDTH-1:1]};
          cnt    <= cnt + CNT_WIDTH'(1);
        end
        FIXLO: begin
          loWord   <= sum;
          fixCarry <= carryOut;
        end
        default: ;
      endcase
    end
  end

  // HI/LO change only on the final fix-up pass or on MTHI/MTLO while idle.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
      bus.hi   <= '0;
      bus.lo   <= '0;
    end else begin
      bus.busy <= busyD;
      bus.done <= doneD;
      if (state == FIXHI) begin
        bus.hi <= sum;
        bus.lo <= loWord;
      end else if (state == IDLE) begin
        if (bus.hiWrite) bus.hi <= bus.writeData;
        if (bus.loWrite) bus.lo <= bus.writeData;
      end
    end
  end

endmodule
